demux1x3_reg: RTL
=================

Name: demux1x3_reg

Overview:
- Registered 1-to-3 demultiplexer with valid/ready handshakes. The write side of the datapath's 3-input select: one 16-bit producer stream is steered to one of three consumers (A, B, C) chosen by a 2-bit select.
- Sits between a result source (ALU or memory read data) and three destinations in the multicycle datapath.
- Provides a one-word holding stage so back-pressure from the chosen destination stalls the producer without losing data.

Parameters:
- WIDTH, 16, data width of the input and all three outputs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word offered by the producer.
- in_sel  input  2  destination: 2'b00 -> A, 2'b01 -> B, 2'b10 or 2'b11 -> C.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts the offer this cycle.
- out_data  output  WIDTH  held word, broadcast to all three destinations.
- a_valid / b_valid / c_valid  output  1 each  held word is destined for A / B / C; at most one is high.
- a_ready / b_ready / c_ready  input  1 each  destination accepts the held word.
- busy  output  1  holding register occupied (equals state FULL).

Behaviour:
- Reset (async, immediate): state EMPTY, out_data = 0, held select = 2'b00, a/b/c_valid = 0, busy = 0. in_ready is 1 combinationally once reset deasserts.
- Select decode: 2'b00 -> A, 2'b01 -> B, 2'b10 -> C, 2'b11 -> C (same default-to-C rule as the datapath mux). The decoded one-hot is stored, not the raw code.
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: x_valid & x_ready for the held destination x.
- The ready inputs of non-selected destinations are ignored.
- in_ready = (state == EMPTY) | (output transfer this cycle). It is combinational from the x_ready inputs. No combinational path from in_valid to in_ready.
- State EMPTY:
  - Input transfer -> capture in_data and decoded select; go to FULL.
  - Otherwise stay in EMPTY; out_data holds its last value; all x_valid = 0.
- State FULL: exactly one x_valid = 1, per the held select.
  - Output transfer with no input transfer -> EMPTY; out_data retains its value.
  - Output transfer with a simultaneous input transfer -> stay FULL and load the new word and select in the same edge (full throughput, one word per cycle).
  - No output transfer -> hold data, select and valid stable. in_ready = 0.
- Latency: a word accepted at edge N appears on out_data with x_valid high after edge N. Minimum latency is 1 cycle. Throughput is 1 word/cycle when the destination is always ready.
- Consecutive words to different destinations: the valid moves from one output to another at the edge where the first word drains. There is no bubble.
- No data dependence: in_data passes unmodified; no width conversion.
- Destination never ready: the block stays FULL indefinitely; the producer is stalled; no data is lost or duplicated.
- Reset mid-operation: the held word is discarded, valids drop immediately (async), and the state returns to EMPTY.
- in_sel changes while in_valid is low: no effect.

Decomposition:
- Shared package: destination select encodings SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, and a 2-state type (EMPTY, FULL), for reuse by the datapath mux and control unit.
- One natural sub-module: sel_decode3, a combinational 2-bit -> 3-bit one-hot decoder that folds 2'b11 into C.
- Everything else (state register, holding register, ready logic) lives in the top module.

Test Plan:
- Basic steering, all ready = 1:
  - Stimulus: in_data = 16'hAAAA/sel 00, then 16'h5555/sel 01, then 16'hFFFF/sel 10, one per cycle.
  - Required: out_data = AAAA with a_valid only, then 5555 with b_valid only, then FFFF with c_valid only, each 1 cycle after acceptance; in_ready = 1 throughout.
- Select 11:
  - Stimulus: 16'h1234 with sel 11.
  - Required: c_valid = 1, a_valid = b_valid = 0, out_data = 1234.
- Back-pressure:
  - Stimulus: 16'hAAAA/sel 01 with b_ready = 0 for 3 cycles while the producer holds 16'h5555/sel 00 valid; a_ready = 1.
  - Required: in_ready = 0 and b_valid = 1 with out_data = AAAA stable for 3 cycles. On the cycle b_ready = 1, in_ready = 1 and 5555 is loaded; the next cycle shows a_valid = 1, out_data = 5555.
- Wrong-destination ready:
  - Stimulus: held word for A with a_ready = 0, b_ready = c_ready = 1.
  - Required: state stays FULL, in_ready = 0, no word lost.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) while FULL with c_valid = 1.
  - Required: c_valid, busy and out_data go to 0 without waiting for a clock edge. After release, in_ready = 1 and the next word is accepted normally.
- Idle/drain: after the last word drains with no new in_valid, busy = 0 and all valids = 0 on the next cycle.

Source files
------------

// File: rtl/demux1x3_reg_pkg.sv
// demux1x3_reg_pkg
//   Shared definitions for the datapath destination steering logic.
//   SEL_A/SEL_B/SEL_C : 2-bit destination select encodings (2'b11 also means C).
//   dmx_state_t       : holding-stage occupancy (EMPTY, FULL).
//   DST_A/DST_B/DST_C : bit positions of each destination in a one-hot select.
package demux1x3_reg_pkg;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  localparam int DST_A = 0;
  localparam int DST_B = 1;
  localparam int DST_C = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } dmx_state_t;

endpackage

// File: rtl/demux1x3_reg_sel_decode3.sv
// sel_decode3
//   Combinational 2-bit destination code -> 3-bit one-hot.
//   sel    : destination code (00 A, 01 B, 10/11 C)
//   onehot : bit DST_A/DST_B/DST_C set for the chosen destination
module sel_decode3
  import demux1x3_reg_pkg::*;
(
  input  logic [1:0] sel,
  output logic [2:0] onehot
);

  always_comb begin
    onehot = '0;
    case (sel)
      SEL_A:   onehot[DST_A] = 1'b1;
      SEL_B:   onehot[DST_B] = 1'b1;
      // 2'b11 falls through to C, matching the datapath mux default.
      default: onehot[DST_C] = 1'b1;
    endcase
  end

endmodule

// File: rtl/demux1x3_reg.sv
// demux1x3_reg
//   Registered 1-to-3 demux with valid/ready handshakes and a one-word
//   holding stage. The producer word is steered to destination A, B or C.
//   clk, reset            : rising-edge clock, async active-high reset
//   in_data/in_sel        : offered word and destination code
//   in_valid/in_ready     : producer handshake
//   out_data              : held word, broadcast to all destinations
//   a/b/c_valid, a/b/c_ready : per-destination handshake (at most one valid)
//   busy                  : holding register occupied
module demux1x3_reg
  import demux1x3_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  output logic             busy
);

  dmx_state_t state;
  logic [2:0] sel_oh;
  logic [2:0] vld_q;   // held one-hot destination, all-zero while EMPTY
  logic       out_xfer;
  logic       in_xfer;

  sel_decode3 u_dec (
    .sel    (in_sel),
    .onehot (sel_oh)
  );

  // Only the held destination's ready matters: vld_q masks the others.
  assign out_xfer = |(vld_q & {c_ready, b_ready, a_ready});
  // Depends on the ready inputs and registered state only, never in_valid.
  assign in_ready = (state == EMPTY) | out_xfer;
  assign in_xfer  = in_valid & in_ready;

  assign a_valid = vld_q[DST_A];
  assign b_valid = vld_q[DST_B];
  assign c_valid = vld_q[DST_C];
  assign busy    = (state == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      out_data <= '0;
      vld_q    <= '0;
    end else if (in_xfer) begin
      // Covers both a fill from EMPTY and a back-to-back reload while draining.
      state    <= FULL;
      out_data <= in_data;
      vld_q    <= sel_oh;
    end else if (out_xfer) begin
      // Drain with nothing behind it; out_data keeps its last value.
      state <= EMPTY;
      vld_q <= '0;
    end
  end

endmodule
